// File: rtl/card_dealer.sv
// Card source for the blackjack controller: deals from one 52-card deck.
// Ports: clk, rst (async low), request/shuffle in; ready, cval, suit,
// cards_left, empty out. `define CARD_DEALER_FIXED_ORDER_EN to deal
// cards in index order 0..51 instead of LFSR order.
module card_dealer #(
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter bit         AUTO_RESHUFFLE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       request,
  input  logic       shuffle,
  output logic       ready,
  output logic [3:0] cval,
  output logic [1:0] suit,
  output logic [5:0] cards_left,
  output logic       empty
);

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    PRESENT,
    DRY
  } state_t;

  state_t      state;
  logic [7:0]  lfsr;
  logic        fb;
  logic [51:0] used;
  logic [5:0]  p;
  logic [5:0]  p_next;
  logic [5:0]  cand;
  logic [5:0]  cand_fresh;
  logic [5:0]  rank6;
  logic [3:0]  rank;
  logic [1:0]  d_suit;
  logic [3:0]  d_cval;

`ifdef CARD_DEALER_FIXED_ORDER_EN
  logic [5:0]  ptr;
`endif

  assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  assign p_next = (p == 6'd51) ? 6'd0 : p + 6'd1;

`ifdef CARD_DEALER_FIXED_ORDER_EN
  // an auto-reshuffle also rewinds the pointer, so the first card is 0
  assign cand       = ptr;
  assign cand_fresh = 6'd0;
`else
  assign cand = (lfsr[5:0] >= 6'd52) ? lfsr[5:0] - 6'd52
                                     : lfsr[5:0];
  assign cand_fresh = cand;
`endif

  always_comb begin
    d_suit = 2'd0;
    rank6  = p;
    unique case (1'b1)
      (p < 6'd13): begin
        d_suit = 2'd0;
        rank6  = p;
      end
      (p >= 6'd13 && p < 6'd26): begin
        d_suit = 2'd1;
        rank6  = p - 6'd13;
      end
      (p >= 6'd26 && p < 6'd39): begin
        d_suit = 2'd2;
        rank6  = p - 6'd26;
      end
      (p >= 6'd39): begin
        d_suit = 2'd3;
        rank6  = p - 6'd39;
      end
    endcase
  end

  assign rank = rank6[3:0];

  always_comb begin
    d_cval = 4'd10;
    unique case (1'b1)
      (rank == 4'd0):                 d_cval = 4'd11;
      (rank >= 4'd1 && rank <= 4'd9): d_cval = rank + 4'd1;
      default:                        d_cval = 4'd10;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      used       <= '0;
      p          <= '0;
      ready      <= 1'b0;
      cval       <= '0;
      suit       <= '0;
      cards_left <= 6'd52;
      empty      <= 1'b0;
`ifdef CARD_DEALER_FIXED_ORDER_EN
      ptr        <= '0;
`endif
    end else begin
      lfsr <= {lfsr[6:0], fb};
      unique case (state)
        IDLE: begin
          ready <= 1'b0;
          if (shuffle) begin
            used       <= '0;
            cards_left <= 6'd52;
            empty      <= 1'b0;
`ifdef CARD_DEALER_FIXED_ORDER_EN
            ptr        <= '0;
`endif
          end else if (request) begin
            if (cards_left != 6'd0) begin
              p     <= cand;
              state <= PROBE;
            end else if (AUTO_RESHUFFLE) begin
              used       <= '0;
              cards_left <= 6'd52;
              p          <= cand_fresh;
              state      <= PROBE;
`ifdef CARD_DEALER_FIXED_ORDER_EN
              ptr        <= '0;
`endif
            end else begin
              empty <= 1'b1;
              state <= DRY;
            end
          end
        end
        PROBE: begin
          // linear probe; a free slot exists because cards_left > 0
          if (used[p]) begin
            p <= p_next;
          end else begin
            used[p]    <= 1'b1;
            cval       <= d_cval;
            suit       <= d_suit;
            cards_left <= cards_left - 6'd1;
            ready      <= 1'b1;
            state      <= PRESENT;
`ifdef CARD_DEALER_FIXED_ORDER_EN
            ptr        <= (ptr == 6'd51) ? 6'd0 : ptr + 6'd1;
`endif
          end
        end
        PRESENT: begin
          if (!request) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        DRY: begin
          ready <= 1'b0;
          if (shuffle) begin
            used       <= '0;
            cards_left <= 6'd52;
            empty      <= 1'b0;
            state      <= IDLE;
`ifdef CARD_DEALER_FIXED_ORDER_EN
            ptr        <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: stalling and auto-reshuffle instances share
// stimulus; a deck model fills a scoreboard of expected cards.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       request = 1'b0;
  logic       shuffle = 1'b0;
  logic       r0, e0, r1, e1;
  logic [3:0] cv0, cv1;
  logic [1:0] s0, s1;
  logic [5:0] cl0, cl1;

  always #5 clk = ~clk;

  card_dealer #(
    .LFSR_SEED     (8'hA5),
    .AUTO_RESHUFFLE(1'b0)
  ) u_dry (
    .clk       (clk),
    .rst       (rst),
    .request   (request),
    .shuffle   (shuffle),
    .ready     (r0),
    .cval      (cv0),
    .suit      (s0),
    .cards_left(cl0),
    .empty     (e0)
  );

  card_dealer #(
    .LFSR_SEED     (8'hA5),
    .AUTO_RESHUFFLE(1'b1)
  ) u_auto (
    .clk       (clk),
    .rst       (rst),
    .request   (request),
    .shuffle   (shuffle),
    .ready     (r1),
    .cval      (cv1),
    .suit      (s1),
    .cards_left(cl1),
    .empty     (e1)
  );

  logic [7:0] lfsr_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= 8'hA5;
    else lfsr_m <= {lfsr_m[6:0],
                    lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  typedef struct {
    int cval;
    int suit;
    int lat;
  } exp_t;

  exp_t sb[$];
  bit   used_m[52];
  int   left_m;
  int   ptr_m;
  int   errs = 0;
  int   checks = 0;
  int   sum = 0;
  int   hist[4][12];

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int lfsr_cand();
    int c;
    c = int'(lfsr_m[5:0]);
    if (c >= 52) c = c - 52;
    return c;
  endfunction

  function automatic int cand();
`ifdef CARD_DEALER_FIXED_ORDER_EN
    return ptr_m;
`else
    return lfsr_cand();
`endif
  endfunction

  function automatic int fresh_cand();
`ifdef CARD_DEALER_FIXED_ORDER_EN
    return 0;
`else
    return lfsr_cand();
`endif
  endfunction

  function automatic void decode(input int i,
                                 output int cv,
                                 output int s);
    int r;
    s = i / 13;
    r = i % 13;
    if (r == 0) cv = 11;
    else if (r <= 9) cv = r + 1;
    else cv = 10;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 52; i++) used_m[i] = 1'b0;
    left_m = 52;
    ptr_m  = 0;
  endtask

  // called just before the edge that samples request in IDLE
  task automatic predict();
    int c, k, cv, s;
    exp_t e;
    c = cand();
    k = 0;
    while (used_m[c]) begin
      c = (c == 51) ? 0 : c + 1;
      k++;
    end
    used_m[c] = 1'b1;
    left_m--;
    ptr_m = (ptr_m == 51) ? 0 : ptr_m + 1;
    decode(c, cv, s);
    e.cval = cv;
    e.suit = s;
    e.lat  = k + 2;
    sb.push_back(e);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!r0 && n < 60);
    if (!r0) chk("ready_timeout", 0, 1);
  endtask

  task automatic serve(input bit both);
    int   n;
    exp_t e;
    predict();
    request = 1'b1;
    wait_ready(n);
    e = sb.pop_front();
    chk("cval", cv0, e.cval);
    chk("suit", s0, e.suit);
    chk("latency", n, e.lat);
    chk("cards_left", cl0, left_m);
    if (both) begin
      chk("auto_cval", cv1, e.cval);
      chk("auto_left", cl1, left_m);
    end
    sum += int'(cv0);
    if (cv0 >= 2 && cv0 <= 11) hist[s0][cv0]++;
    request = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_drop", r0, 0);
  endtask

  initial begin
    int n, n1, bad, c, cv1e, s1e;
    logic [3:0] cv1c;
    logic [1:0] s1c;
    logic [5:0] cl1c;
    model_clear();
    for (int s = 0; s < 4; s++)
      for (int v = 0; v < 12; v++) hist[s][v] = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", r0, 0);
    chk("rst_cval", cv0, 0);
    chk("rst_suit", s0, 0);
    chk("rst_left", cl0, 52);
    chk("rst_empty", e0, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 52; i++) serve(1'b1);
    chk("cval_sum", sum, 380);
    bad = 0;
    for (int s = 0; s < 4; s++)
      for (int v = 2; v <= 11; v++)
        if (hist[s][v] != ((v == 10) ? 4 : 1)) bad++;
    chk("deck_hist", bad, 0);
    chk("left_zero", cl0, 0);
    chk("auto_left_zero", cl1, 0);
    chk("empty_before", e0, 0);

    c = fresh_cand();
    decode(c, cv1e, s1e);
    request = 1'b1;
    n1   = 0;
    bad  = 0;
    cv1c = '0;
    s1c  = '0;
    cl1c = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (r0) bad++;
      if (!e0) bad++;
      if (e1) bad++;
      if (r1 && n1 == 0) begin
        n1   = i;
        cv1c = cv1;
        s1c  = s1;
        cl1c = cl1;
      end
    end
    chk("dry_stall", bad, 0);
    chk("auto_lat", n1, 2);
    chk("auto_cval", cv1c, cv1e);
    chk("auto_suit", s1c, s1e);
    chk("auto_left", cl1c, 51);

    shuffle = 1'b1;
    @(posedge clk);
    @(negedge clk);
    shuffle = 1'b0;
    model_clear();
    chk("shuf_empty", e0, 0);
    chk("shuf_left", cl0, 52);
    chk("auto_hold", r1, 1);
    serve(1'b0);
    chk("auto_release", r1, 0);

    request = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("probe_rst_ready", r0, 0);
    chk("probe_rst_left", cl0, 52);
    request = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    serve(1'b0);

    request = 1'b1;
    wait_ready(n);
    rst = 1'b0;
    #1;
    chk("pres_rst_ready", r0, 0);
    chk("pres_rst_left", cl0, 52);
    request = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    serve(1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
